// File: rtl/wt_mac_8b.sv
// wt_mac_8b: operand feeder and product accumulator for an external
// combinational 8x8 Wallace-tree multiplier. Operand pairs are registered
// onto mul_a/mul_b, the product mul_s is captured one cycle later, and
// products are summed until the pair tagged last. The dot-product result is
// then held on a valid/ready output until the consumer takes it.
module wt_mac_8b #(
  parameter int ACC_W = 24,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  input  logic             in_last,
  output logic [7:0]       mul_a,
  output logic [7:0]       mul_b,
  input  logic [15:0]      mul_s,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  localparam logic [1:0] ACCEPT = 2'd0;
  localparam logic [1:0] FLUSH  = 2'd1;
  localparam logic [1:0] HOLD   = 2'd2;

  logic [1:0]       state;
  logic             started;
  logic             accept;
  logic             outFire;

  logic             vld_p1;
  logic             last_p1;
  logic [15:0]      prod_p2;
  logic             vld_p2;
  logic             last_p2;

  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf;
  logic [ACC_W:0]   sumExt;
  logic [CNT_W-1:0] cntNext;

  // Element counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  // Unsigned add of a zero-extended product; the top bit is the carry-out.
  function automatic logic [ACC_W:0] addCarry(input logic [ACC_W-1:0] a,
                                              input logic [15:0]      p);
    return (ACC_W+1)'(a) + (ACC_W+1)'(p);
  endfunction

  // started keeps in_ready low until the first edge after reset release.
  assign in_ready  = started && (state == ACCEPT);
  assign out_valid = (state == HOLD);
  assign accept    = in_valid && in_ready;
  assign outFire   = out_valid && out_ready;
  assign sumExt    = addCarry(acc, prod_p2);
  assign cntNext   = satInc(cnt);

  // Control FSM: ACCEPT until the last pair is taken, FLUSH while it is in
  // the pipe, HOLD while the result waits for the consumer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ACCEPT;
      started <= 1'b0;
    end else begin
      started <= 1'b1;
      case (state)
        ACCEPT:  if (accept && in_last) state <= FLUSH;
        FLUSH:   if (vld_p2 && last_p2) state <= HOLD;
        HOLD:    if (outFire) state <= ACCEPT;
        default: state <= ACCEPT;
      endcase
    end
  end

  // ---- stage 1: operand registers feeding the multiplier ----
  // Operands only move on an accepted pair so the multiplier inputs stay quiet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_a   <= '0;
      mul_b   <= '0;
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
    end else begin
      vld_p1 <= accept;
      if (accept) begin
        mul_a   <= in_a;
        mul_b   <= in_b;
        last_p1 <= in_last;
      end
    end
  end

  // ---- stage 2: product capture ----
  // Registers the combinational multiplier output alongside its tags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_p2 <= '0;
      vld_p2  <= 1'b0;
      last_p2 <= 1'b0;
    end else begin
      prod_p2 <= mul_s;
      vld_p2  <= vld_p1;
      last_p2 <= last_p1;
    end
  end

  // ---- stage 3: accumulate and publish ----
  // The last product is folded straight into the result registers and the
  // running state is cleared so the next vector starts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else if (vld_p2) begin
      if (last_p2) begin
        out_sum   <= sumExt[ACC_W-1:0];
        out_count <= cntNext;
        out_ovf   <= ovf | sumExt[ACC_W];
        acc       <= '0;
        cnt       <= '0;
        ovf       <= 1'b0;
      end else begin
        acc <= sumExt[ACC_W-1:0];
        cnt <= cntNext;
        ovf <= ovf | sumExt[ACC_W];
      end
    end
  end

endmodule
